// File: rtl/add_pkg.sv
// Shared definitions for the add-class functional unit: widths, op codes, FSM encoding.
package add_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned TAG_W_DEF  = 4;
    localparam int unsigned LAT_DEF    = 3;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned OP_W       = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_SLT = 3'd5;
    localparam logic [OP_W-1:0] OP_SLL = 3'd6;
    localparam logic [OP_W-1:0] OP_SRL = 3'd7;

    // Tag value meaning "no producer"; never accepted, never broadcast.
    localparam int unsigned TAG_NONE = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

endpackage

// File: rtl/add_alu.sv
// Combinational integer datapath for the add unit; all ops wrap modulo 2^DATA_W.
module add_alu
    import add_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] vj_i,
    input  logic [DATA_W-1:0] vk_i,
    output logic [DATA_W-1:0] res_o
);

    logic [4:0] shamt;
    assign shamt = vk_i[4:0];

    // Result select by op code.
    always_comb begin
        res_o = '0;
        case (op_i)
            OP_ADD: res_o = vj_i + vk_i;
            OP_SUB: res_o = vj_i - vk_i;
            OP_AND: res_o = vj_i & vk_i;
            OP_OR:  res_o = vj_i | vk_i;
            OP_XOR: res_o = vj_i ^ vk_i;
            OP_SLT: res_o = ($signed(vj_i) < $signed(vk_i)) ? DATA_W'(1) : '0;
            OP_SLL: res_o = vj_i << shamt;
            OP_SRL: res_o = vj_i >> shamt;
        endcase
    end

endmodule

// File: rtl/add_fu_cdb.sv
// Add-class functional unit: accept from the reservation station, execute over LAT
// cycles, then hold the result on the CDB request until granted.
module add_fu_cdb
    import add_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF,
    parameter int unsigned LAT    = LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              start,
    input  logic [OP_W-1:0]   op_in,
    input  logic [DATA_W-1:0] vj_in,
    input  logic [DATA_W-1:0] vk_in,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              accept,
    output logic              busy,
    output logic              cdb_req,
    input  logic              cdb_gnt,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data
);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] vj_q, vj_d;
    logic [DATA_W-1:0] vk_q, vk_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] alu_res;
    logic              in_wb;

    add_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i  (op_q),
        .vj_i  (vj_q),
        .vk_i  (vk_q),
        .res_o (alu_res)
    );

    assign in_wb    = (state_q == ST_WB);
    assign busy     = (state_q != ST_IDLE);
    assign cdb_req  = in_wb & ~rst;
    assign cdb_tag  = in_wb ? tag_q : '0;
    assign cdb_data = in_wb ? res_q : '0;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            vj_q    <= '0;
            vk_q    <= '0;
            tag_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            vj_q    <= vj_d;
            vk_q    <= vk_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
        end
    end

    // Next state, accept and broadcast handshake; flush overrides grant and start.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        vj_d      = vj_q;
        vk_d      = vk_q;
        tag_d     = tag_q;
        res_d     = res_q;
        accept    = 1'b0;
        cdb_valid = 1'b0;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (tag_in != TAG_W'(TAG_NONE)) && !rst) begin
                        accept  = 1'b1;
                        op_d    = op_in;
                        vj_d    = vj_in;
                        vk_d    = vk_in;
                        tag_d   = tag_in;
                        cnt_d   = CNT_W'(LAT - 1);
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == '0) begin
                        res_d   = alu_res;
                        state_d = ST_WB;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_WB: begin
                    if (cdb_gnt && !rst) begin
                        cdb_valid = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/add_fu_cdb.md
Name: add_fu_cdb

Overview:
- Add-class functional unit directly downstream of the add reservation station.
- Accepts a ready instruction (Op, Vj, Vk, RS tag) when the station asserts start, executes it over a fixed multi-cycle latency, and buffers the result.
- Requests the common data bus (CDB), then broadcasts tag + value for one cycle on grant. The reservation station and register status table use that broadcast to clear their Q fields.

Parameters:
- DATA_W, 32, operand/result width
- TAG_W, 4, tag width; tag 0 means "no producer" and is never broadcast
- LAT, 3, execute cycles from accept to result ready (legal 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  synchronous squash of any in-flight operation
- start  in  1  station operands ready, request to execute
- op_in  in  3  operation code
- vj_in  in  DATA_W  source operand j
- vk_in  in  DATA_W  source operand k
- tag_in  in  TAG_W  issuing station tag
- accept  out  1  operation captured this cycle
- busy  out  1  unit occupied (EXEC or WB)
- cdb_req  out  1  request CDB
- cdb_gnt  in  1  CDB grant from arbiter
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  DATA_W  broadcast value

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, counter=0, operand/tag/result registers=0. All outputs 0.
- FSM states:
  - IDLE: accept = start & ~flush (combinational).
    - On accept, latch op/vj/vk/tag, load cnt=LAT-1, go to EXEC.
    - tag_in==0 with start is illegal and is ignored (no accept).
  - EXEC: cnt decrements each cycle.
    - In the cycle cnt==0, register the result and go to WB.
    - Accept cycle T gives result registered at the end of cycle T+LAT. cdb_req is first high in cycle T+LAT+1.
  - WB: cdb_req=1. cdb_tag/cdb_data are driven from registers and held stable while waiting.
    - cdb_valid = cdb_req & cdb_gnt, combinational, and high for exactly one cycle.
    - On grant, go to IDLE.
    - No new accept in WB, even in the grant cycle. The earliest next accept is the cycle after the grant.
- Outputs:
  - busy = state != IDLE.
  - cdb_req/cdb_valid = 0 outside WB.
  - cdb_gnt without cdb_req is ignored.
- flush: in any state, next state is IDLE and cnt=0.
  - cdb_valid is forced 0 in the flush cycle, even with gnt; flush beats grant.
  - flush in IDLE with start: no accept.
- Priority: rst > flush > grant > start.
- Ops (3 bits), all DATA_W-wide with modulo-2^DATA_W wrap and no overflow flag:
  - 0 ADD
  - 1 SUB
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLT (signed compare, result 0/1)
  - 6 SLL
  - 7 SRL (logical)
- Shift amount is vk[4:0].
- Result is computed from the latched operands only; input changes after accept have no effect.

Decomposition:
- Shared package add_pkg: DATA_W/TAG_W defaults, op encodings, TAG_NONE=0, FSM state encoding.
- Sub-module add_alu: purely combinational op/vj/vk -> result. The FSM, counter and CDB handshake stay in add_fu_cdb.

Test Plan:
- ADD, LAT=3: start with op=0, vj=5, vk=7, tag=3 at cycle 0 -> accept=1 at cycle 0; cdb_req first high at cycle 4; gnt at cycle 4 -> cdb_valid=1, tag=3, data=12 for one cycle; busy=0 at cycle 5.
- Wrap and signed ops: ADD 0xFFFFFFFF+1 -> 0. SUB 0-1 -> 0xFFFFFFFF. SLT 0xFFFFFFFF vs 1 -> 1. SRL 0x80000000 by vk=33 -> shift 1 -> 0x40000000.
- Grant held off 5 cycles: cdb_req stays high with tag/data stable; a start during the wait gets accept=0; accept is possible the cycle after the grant.
- Flush in EXEC, and flush coinciding with cdb_gnt in WB: cdb_valid=0, state IDLE next cycle, no later broadcast of that tag.
- rst asserted mid-EXEC: all outputs 0 next cycle; start with tag_in=0 -> no accept, busy stays 0.
- LAT=1 parameter run: accept at cycle 0 -> cdb_req at cycle 2; back-to-back ops with immediate grants produce alternating accept/broadcast without loss.
